// File: rtl/load_store_unit.sv
// Data-side load/store unit between the execute stage and RAM port A.
// Handles byte/halfword/word accesses with lane steering, alignment/range faults and read latency.
module load_store_unit #(
   parameter int MEM_WORDS_LOG2 = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        zero_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic        done,
   output logic [31:0] rdata,
   output logic [1:0]  fault,
   output logic [29:0] ram_address,
   output logic [31:0] ram_data,
   output logic [3:0]  ram_byteena,
   output logic        ram_wren,
   input  logic [31:0] ram_q
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [30:0] WORD_LIMIT = 31'(1) << MEM_WORDS_LOG2;

   logic [1:0]  state;
   logic        we_q;
   logic [1:0]  size_q;
   logic        zero_ext_q;
   logic [1:0]  lane_q;

   logic        misaligned;
   logic        out_of_range;
   logic [3:0]  req_byteena;
   logic [31:0] req_data;
   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_value;

   assign ready = (state == S_IDLE) || (state == S_DONE);
   assign done  = (state == S_DONE);

   // Decode the incoming request: fault bits plus lane steering for the RAM.
   always_comb begin
      misaligned   = (size == 2'b11)
                   | ((size == 2'b01) & addr[0])
                   | ((size == 2'b10) & (addr[1:0] != 2'b00));
      out_of_range = {1'b0, addr[31:2]} >= WORD_LIMIT;
      case (size)
         2'b00: begin
            req_byteena = 4'b0001 << addr[1:0];
            req_data    = {4{wdata[7:0]}};
         end
         2'b01: begin
            req_byteena = 4'b0011 << {addr[1], 1'b0};
            req_data    = {2{wdata[15:0]}};
         end
         default: begin
            req_byteena = 4'b1111;
            req_data    = wdata;
         end
      endcase
   end

   // Pick the addressed lane(s) out of the RAM word and extend to 32 bits.
   always_comb begin
      load_byte = ram_q[{lane_q, 3'b000} +: 8];
      load_half = ram_q[{lane_q[1], 4'b0000} +: 16];
      case (size_q)
         2'b00:   load_value = {{24{~zero_ext_q & load_byte[7]}}, load_byte};
         2'b01:   load_value = {{16{~zero_ext_q & load_half[15]}}, load_half};
         default: load_value = ram_q;
      endcase
   end

   // Handshake FSM; ram_wren is only ever high while in ACCESS, and reset clears it at once.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         we_q        <= 1'b0;
         size_q      <= 2'b00;
         zero_ext_q  <= 1'b0;
         lane_q      <= 2'b00;
         rdata       <= 32'd0;
         fault       <= 2'b00;
         ram_address <= 30'd0;
         ram_data    <= 32'd0;
         ram_byteena <= 4'b0000;
         ram_wren    <= 1'b0;
      end else begin
         ram_wren <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               rdata <= 32'd0;
               if (req) begin
                  we_q       <= we;
                  size_q     <= size;
                  zero_ext_q <= zero_ext;
                  lane_q     <= addr[1:0];
                  fault      <= {out_of_range, misaligned};
                  if (misaligned || out_of_range) begin
                     state <= S_DONE;
                  end else begin
                     state       <= S_ACCESS;
                     ram_address <= addr[31:2];
                     ram_byteena <= req_byteena;
                     ram_data    <= req_data;
                     ram_wren    <= we;
                  end
               end else begin
                  state <= S_IDLE;
                  fault <= 2'b00;
               end
            end
            S_ACCESS: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               rdata <= we_q ? 32'd0 : load_value;
               state <= S_DONE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a behavioural one-cycle-latency RAM on port A.
module tb_load_store_unit;

   logic        clock;
   logic        reset;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        zero_ext;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ready;
   logic        done;
   logic [31:0] rdata;
   logic [1:0]  fault;
   logic [29:0] ram_address;
   logic [31:0] ram_data;
   logic [3:0]  ram_byteena;
   logic        ram_wren;
   logic [31:0] ram_q;

   logic [31:0] mem [0:65535];

   int compare_count = 0;
   int fail_count    = 0;

   load_store_unit #(.MEM_WORDS_LOG2(16)) dut (
      .clock       (clock),
      .reset       (reset),
      .req         (req),
      .we          (we),
      .size        (size),
      .zero_ext    (zero_ext),
      .addr        (addr),
      .wdata       (wdata),
      .ready       (ready),
      .done        (done),
      .rdata       (rdata),
      .fault       (fault),
      .ram_address (ram_address),
      .ram_data    (ram_data),
      .ram_byteena (ram_byteena),
      .ram_wren    (ram_wren),
      .ram_q       (ram_q)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // RAM with registered address: write lanes and read old word on the same edge.
   always @(posedge clock) begin
      if (ram_wren) begin
         if (ram_byteena[0]) mem[ram_address[15:0]][7:0]   <= ram_data[7:0];
         if (ram_byteena[1]) mem[ram_address[15:0]][15:8]  <= ram_data[15:8];
         if (ram_byteena[2]) mem[ram_address[15:0]][23:16] <= ram_data[23:16];
         if (ram_byteena[3]) mem[ram_address[15:0]][31:24] <= ram_data[31:24];
      end
      ram_q <= mem[ram_address[15:0]];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compare_count++;
      assert (observed === expected) else begin
         fail_count++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Present one request for a single edge; returns at the negedge of cycle 1.
   task automatic applyStimulus(input logic is_store, input logic [1:0] sz, input logic zx,
                                input logic [31:0] a, input logic [31:0] wd);
      @(negedge clock);
      req      = 1'b1;
      we       = is_store;
      size     = sz;
      zero_ext = zx;
      addr     = a;
      wdata    = wd;
      @(negedge clock);
      req = 1'b0;
   endtask

   task automatic doAccess(input string tag, input logic is_store, input logic [1:0] sz, input logic zx,
                           input logic [31:0] a, input logic [31:0] wd, input logic [29:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_ram_data,
                           input logic [31:0] exp_rdata);
      applyStimulus(is_store, sz, zx, a, wd);
      checkOutput({tag, ".c1_ready"}, 32'(ready), 32'd0);
      checkOutput({tag, ".c1_wren"}, 32'(ram_wren), 32'(is_store));
      checkOutput({tag, ".c1_address"}, 32'(ram_address), 32'(exp_addr));
      checkOutput({tag, ".c1_byteena"}, 32'(ram_byteena), 32'(exp_be));
      if (is_store) checkOutput({tag, ".c1_ram_data"}, ram_data, exp_ram_data);
      @(negedge clock);
      checkOutput({tag, ".c2_wren"}, 32'(ram_wren), 32'd0);
      checkOutput({tag, ".c2_done"}, 32'(done), 32'd0);
      @(negedge clock);
      checkOutput({tag, ".c3_done"}, 32'(done), 32'd1);
      checkOutput({tag, ".c3_ready"}, 32'(ready), 32'd1);
      checkOutput({tag, ".c3_rdata"}, rdata, exp_rdata);
      checkOutput({tag, ".c3_fault"}, 32'(fault), 32'd0);
   endtask

   task automatic doFault(input string tag, input logic [1:0] sz, input logic [31:0] a,
                          input logic [1:0] exp_fault);
      applyStimulus(1'b1, sz, 1'b0, a, 32'hFFFF_FFFF);
      checkOutput({tag, ".c1_done"}, 32'(done), 32'd1);
      checkOutput({tag, ".c1_fault"}, 32'(fault), 32'(exp_fault));
      checkOutput({tag, ".c1_rdata"}, rdata, 32'd0);
      checkOutput({tag, ".c1_wren"}, 32'(ram_wren), 32'd0);
      @(negedge clock);
      checkOutput({tag, ".c2_done"}, 32'(done), 32'd0);
      checkOutput({tag, ".c2_fault"}, 32'(fault), 32'd0);
      checkOutput({tag, ".c2_wren"}, 32'(ram_wren), 32'd0);
   endtask

   initial begin
      reset    = 1'b1;
      req      = 1'b0;
      we       = 1'b0;
      size     = 2'b00;
      zero_ext = 1'b0;
      addr     = 32'd0;
      wdata    = 32'd0;
      repeat (2) @(negedge clock);
      checkOutput("reset.ready", 32'(ready), 32'd1);
      checkOutput("reset.done", 32'(done), 32'd0);
      checkOutput("reset.rdata", rdata, 32'd0);
      checkOutput("reset.fault", 32'(fault), 32'd0);
      checkOutput("reset.address", 32'(ram_address), 32'd0);
      checkOutput("reset.ram_data", ram_data, 32'd0);
      checkOutput("reset.byteena", 32'(ram_byteena), 32'd0);
      checkOutput("reset.wren", 32'(ram_wren), 32'd0);
      reset = 1'b0;

      doAccess("st_word", 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 30'h40, 4'b1111, 32'hDEAD_BEEF, 32'h0);
      doAccess("ld_word", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 30'h40, 4'b1111, 32'h0, 32'hDEAD_BEEF);
      doAccess("st_preload", 1'b1, 2'b10, 1'b0, 32'h100, 32'h8000_0000, 30'h40, 4'b1111, 32'h8000_0000, 32'h0);
      doAccess("st_byte3", 1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_007F, 30'h40, 4'b1000, 32'h7F7F_7F7F, 32'h0);
      doAccess("ld_sbyte3", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 30'h40, 4'b1000, 32'h0, 32'h0000_007F);
      doAccess("ld_sbyte0", 1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 30'h40, 4'b0001, 32'h0, 32'h0000_0000);
      doAccess("st_half2", 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_8001, 30'h40, 4'b1100, 32'h8001_8001, 32'h0);
      doAccess("ld_shalf2", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 30'h40, 4'b1100, 32'h0, 32'hFFFF_8001);
      doAccess("ld_zhalf2", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 30'h40, 4'b1100, 32'h0, 32'h0000_8001);
      doAccess("ld_sbyte3b", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 30'h40, 4'b1000, 32'h0, 32'hFFFF_FF80);
      doAccess("ld_zbyte3", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 30'h40, 4'b1000, 32'h0, 32'h0000_0080);
      doAccess("ld_sbyte2", 1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 30'h40, 4'b0100, 32'h0, 32'h0000_0001);
      doAccess("ld_shalf0", 1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 30'h40, 4'b0011, 32'h0, 32'h0000_0000);
      checkOutput("mem_word_0x100", mem[16'h40], 32'h8001_0000);

      doFault("f_half_odd", 2'b01, 32'h0000_0101, 2'b01);
      doFault("f_word_half", 2'b10, 32'h0000_0102, 2'b01);
      doFault("f_size11", 2'b11, 32'h0000_0100, 2'b01);
      doFault("f_range", 2'b10, 32'h0004_0000, 2'b10);
      doFault("f_both", 2'b10, 32'h0004_0001, 2'b11);
      checkOutput("mem_after_faults", mem[16'h40], 32'h8001_0000);

      // Second request presented while the first is in DONE.
      doAccess("b2b_st", 1'b1, 2'b10, 1'b0, 32'h200, 32'h1234_5678, 30'h80, 4'b1111, 32'h1234_5678, 32'h0);
      req      = 1'b1;
      we       = 1'b0;
      size     = 2'b10;
      zero_ext = 1'b0;
      addr     = 32'h200;
      wdata    = 32'h0;
      @(negedge clock);
      req = 1'b0;
      checkOutput("b2b_ld.c1_done", 32'(done), 32'd0);
      checkOutput("b2b_ld.c1_address", 32'(ram_address), 32'h80);
      @(negedge clock);
      checkOutput("b2b_ld.c2_done", 32'(done), 32'd0);
      @(negedge clock);
      checkOutput("b2b_ld.c3_done", 32'(done), 32'd1);
      checkOutput("b2b_ld.c3_rdata", rdata, 32'h1234_5678);

      // Reset pulse in the ACCESS cycle of a store must abort the write.
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h200, 32'hAAAA_AAAA);
      checkOutput("rst_acc.wren_before", 32'(ram_wren), 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("rst_acc.wren_async", 32'(ram_wren), 32'd0);
      checkOutput("rst_acc.ready_async", 32'(ready), 32'd1);
      @(negedge clock);
      reset = 1'b0;
      checkOutput("rst_acc.done", 32'(done), 32'd0);
      checkOutput("rst_acc.mem", mem[16'h80], 32'h1234_5678);
      @(negedge clock);
      checkOutput("rst_acc.done_after", 32'(done), 32'd0);
      checkOutput("rst_acc.ready_after", 32'(ready), 32'd1);
      doAccess("rst_reload", 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 30'h80, 4'b1111, 32'h0, 32'h1234_5678);

      repeat (2) @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
      $finish;
   end

endmodule
